// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the two-port cache-to-memory arbiter.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin ties instead of D-cache priority.
package mem_arb_pkg;

  localparam int MEM_ARB_ADDR_W = 28;
  localparam int MEM_ARB_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    LG_I = 1'b0,
    LG_D = 1'b1
  } last_grant_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Next-grant selection between I-cache and D-cache requests.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the port that did not complete last; otherwise D wins.
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic        i_req,
  input  logic        d_req,
  input  last_grant_t last_grant,
  output logic        grant_d
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign grant_d = d_req & (~i_req | (last_grant == LG_I));
`else
  logic w_unused_sel;
  assign w_unused_sel = i_req ^ logic'(last_grant);
  assign grant_d      = d_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache line ports onto one shared memory port.
// MEM_ARB_ROUND_ROBIN_EN enables round-robin arbitration; default is D-cache priority.
//
// state | meaning
// IDLE  | no grant; memory port and both ready strobes held at 0
// GNT_I | I-cache port forwarded to memory until mem_ready or request drop
// GNT_D | D-cache port forwarded to memory until mem_ready or request drop
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ARB_ADDR_W,
  parameter int LINE_W = MEM_ARB_LINE_W
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t  r_state;
  arb_state_t  w_state_nxt;
  last_grant_t w_last_grant;
  logic        w_i_req;
  logic        w_d_req;
  logic        w_grant_d;

  assign w_i_req = i_read | i_write;
  assign w_d_req = d_read | d_write;

  always_ff @(posedge clk) begin
    if (!proc_reset_n) r_state <= IDLE;
    else               r_state <= w_state_nxt;
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  last_grant_t r_last_grant;

  always_ff @(posedge clk) begin
    if (!proc_reset_n)
      r_last_grant <= LG_I;
    else if (mem_ready && r_state == GNT_I)
      r_last_grant <= LG_I;
    else if (mem_ready && r_state == GNT_D)
      r_last_grant <= LG_D;
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = LG_I;
`endif

  mem_arb_sel u_sel (
    .i_req      (w_i_req),
    .d_req      (w_d_req),
    .last_grant (w_last_grant),
    .grant_d    (w_grant_d)
  );

  always_comb begin
    w_state_nxt = r_state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_ready     = 1'b0;
    i_rdata     = '0;
    d_ready     = 1'b0;
    d_rdata     = '0;
    case (r_state)
      IDLE: begin
        if (w_i_req || w_d_req) w_state_nxt = w_grant_d ? GNT_D : GNT_I;
      end
      GNT_I: begin
        mem_read  = i_read;
        mem_write = i_write;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_ready   = mem_ready;
        i_rdata   = mem_rdata;
        if (mem_ready)     w_state_nxt = w_d_req ? GNT_D : IDLE;
        else if (!w_i_req) w_state_nxt = IDLE;
      end
      GNT_D: begin
        mem_read  = d_read;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_ready   = mem_ready;
        d_rdata   = mem_rdata;
        // Request levels in the completion cycle decide whether D keeps the port.
        if (mem_ready) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          w_state_nxt = w_i_req ? GNT_I : IDLE;
`else
          if (w_i_req || w_d_req) w_state_nxt = w_grant_d ? GNT_D : GNT_I;
          else                    w_state_nxt = IDLE;
`endif
        end else if (!w_d_req) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed per-cycle vectors for mem_arbiter; each row drives one cycle and checks the outputs.
// The cache model releases its request in the same cycle memory completes.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int LW = 128;
  localparam logic [AW-1:0] A_I  = 28'h0000020;
  localparam logic [AW-1:0] A_D  = 28'h0000010;
  localparam logic [LW-1:0] WD_I = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [LW-1:0] WD_D = 128'hDDDD_0000_DDDD_0001_DDDD_0002_DDDD_0003;
  localparam logic [LW-1:0] MRD  = 128'hA5A5_0F0F_C3C3_9696_5A5A_F0F0_3C3C_6969;
  localparam logic [1:0] G_N = 2'd0, G_I = 2'd1, G_D = 2'd2;

  typedef struct {
    string      name;
    logic       rst_n, ir, iw, dr, dw, mr;
    logic [1:0] gnt;
    logic       exp_ir, exp_dr, chk;
  } vec_t;

  logic          clk, rst_n;
  logic          i_read, i_write, d_read, d_write, mem_ready;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [LW-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          i_ready, d_ready, mem_read, mem_write;

  int n_pass = 0;
  int n_total = 0;
  vec_t tbl[$];

  mem_arbiter dut (
    .clk(clk), .proc_reset_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string n, input logic rs, ir, iw, dr, dw, mr,
                              input logic [1:0] g, input logic eir, edr, input logic c = 1'b1);
    vec_t v;
    v.name = n; v.rst_n = rs; v.ir = ir; v.iw = iw; v.dr = dr; v.dw = dw; v.mr = mr;
    v.gnt = g; v.exp_ir = eir; v.exp_dr = edr; v.chk = c;
    return v;
  endfunction

  task automatic cmp(input string row, input string what, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s.%s actual=%h required=%h", row, what, act, exp);
    else n_pass++;
  endtask

  task automatic apply(input vec_t v);
    logic [LW-1:0] e_wd, e_ir, e_dr;
    logic [AW-1:0] e_ad;
    logic          e_mr, e_mw;
    @(negedge clk);
    rst_n = v.rst_n; i_read = v.ir; i_write = v.iw; d_read = v.dr; d_write = v.dw;
    mem_ready = v.mr;
    #1;
    if (v.chk) begin
      e_mr = 1'b0; e_mw = 1'b0; e_ad = '0; e_wd = '0; e_ir = '0; e_dr = '0;
      if (v.gnt == G_I) begin
        e_mr = v.ir; e_mw = v.iw; e_ad = A_I; e_wd = WD_I; e_ir = MRD;
      end else if (v.gnt == G_D) begin
        e_mr = v.dr; e_mw = v.dw; e_ad = A_D; e_wd = WD_D; e_dr = MRD;
      end
      cmp(v.name, "mem_read",  LW'(mem_read),  LW'(e_mr));
      cmp(v.name, "mem_write", LW'(mem_write), LW'(e_mw));
      cmp(v.name, "mem_addr",  LW'(mem_addr),  LW'(e_ad));
      cmp(v.name, "mem_wdata", mem_wdata, e_wd);
      cmp(v.name, "i_ready",   LW'(i_ready),   LW'(v.exp_ir));
      cmp(v.name, "d_ready",   LW'(d_ready),   LW'(v.exp_dr));
      cmp(v.name, "i_rdata",   i_rdata, e_ir);
      cmp(v.name, "d_rdata",   d_rdata, e_dr);
    end
  endtask

  // One I-read / D-write tie resolved to first_d, both transfers completed, back to IDLE.
  task automatic tie_round(input string n, input logic first_d);
    apply(mk({n, "_tie"}, 1, 1, 0, 0, 1, 0, G_N, 0, 0));
    if (first_d) begin
      apply(mk({n, "_d"},    1, 1, 0, 0, 1, 0, G_D, 0, 0));
      apply(mk({n, "_d_rd"}, 1, 1, 0, 0, 0, 1, G_D, 0, 1));
      apply(mk({n, "_i"},    1, 1, 0, 0, 0, 0, G_I, 0, 0));
      apply(mk({n, "_i_rd"}, 1, 0, 0, 0, 0, 1, G_I, 1, 0));
    end else begin
      apply(mk({n, "_i"},    1, 1, 0, 0, 1, 0, G_I, 0, 0));
      apply(mk({n, "_i_rd"}, 1, 0, 0, 0, 1, 1, G_I, 1, 0));
      apply(mk({n, "_d"},    1, 0, 0, 0, 1, 0, G_D, 0, 0));
      apply(mk({n, "_d_rd"}, 1, 0, 0, 0, 0, 1, G_D, 0, 1));
    end
    apply(mk({n, "_idle"}, 1, 0, 0, 0, 0, 0, G_N, 0, 0));
  endtask

  initial begin
    rst_n = 1'b0; i_read = 0; i_write = 0; d_read = 0; d_write = 0; mem_ready = 0;
    i_addr = A_I; d_addr = A_D; i_wdata = WD_I; d_wdata = WD_D; mem_rdata = MRD;

    //                 name        rst ir iw dr dw mr gnt  eir edr
    tbl.push_back(mk("rst0",       0, 0, 0, 0, 0, 0, G_N, 0, 0, 0));
    tbl.push_back(mk("rst1",       0, 0, 0, 0, 0, 0, G_N, 0, 0));
    tbl.push_back(mk("d_only_arb", 1, 0, 0, 1, 0, 0, G_N, 0, 0));
    tbl.push_back(mk("d_only_g1",  1, 0, 0, 1, 0, 0, G_D, 0, 0));
    tbl.push_back(mk("d_only_g2",  1, 0, 0, 1, 0, 0, G_D, 0, 0));
    tbl.push_back(mk("d_only_g3",  1, 0, 0, 1, 0, 0, G_D, 0, 0));
    tbl.push_back(mk("d_only_rdy", 1, 0, 0, 0, 0, 1, G_D, 0, 1));
    tbl.push_back(mk("idle_mrdy",  1, 0, 0, 0, 0, 1, G_N, 0, 0));
    tbl.push_back(mk("tie_arb",    1, 1, 0, 0, 1, 0, G_N, 0, 0));
    tbl.push_back(mk("tie_dwr",    1, 1, 0, 0, 1, 0, G_D, 0, 0));
    tbl.push_back(mk("tie_drdy",   1, 1, 0, 0, 0, 1, G_D, 0, 1));
    tbl.push_back(mk("tie_i",      1, 1, 0, 0, 0, 0, G_I, 0, 0));
    tbl.push_back(mk("tie_irdy",   1, 0, 0, 0, 0, 1, G_I, 1, 0));
    tbl.push_back(mk("tie_idle",   1, 0, 0, 0, 0, 0, G_N, 0, 0));
    tbl.push_back(mk("wbrf_arb",   1, 1, 0, 0, 1, 0, G_N, 0, 0));
    tbl.push_back(mk("wbrf_wb",    1, 1, 0, 0, 1, 0, G_D, 0, 0));
    tbl.push_back(mk("wbrf_wbrdy", 1, 1, 0, 0, 1, 1, G_D, 0, 1));
    tbl.push_back(mk("wbrf_rf",    1, 1, 0, 1, 0, 0, G_D, 0, 0));
    tbl.push_back(mk("wbrf_rfrdy", 1, 1, 0, 0, 0, 1, G_D, 0, 1));
    tbl.push_back(mk("wbrf_i",     1, 1, 0, 0, 0, 0, G_I, 0, 0));
    tbl.push_back(mk("wbrf_irdy",  1, 0, 0, 0, 0, 1, G_I, 1, 0));
    tbl.push_back(mk("wbrf_idle",  1, 0, 0, 0, 0, 0, G_N, 0, 0));
    tbl.push_back(mk("ab_arb",     1, 1, 0, 0, 0, 0, G_N, 0, 0));
    tbl.push_back(mk("ab_gi",      1, 1, 0, 1, 0, 0, G_I, 0, 0));
    tbl.push_back(mk("ab_drop",    1, 0, 0, 1, 0, 0, G_I, 0, 0));
    tbl.push_back(mk("ab_idle",    1, 0, 0, 1, 0, 0, G_N, 0, 0));
    tbl.push_back(mk("ab_gd",      1, 0, 0, 1, 0, 0, G_D, 0, 0));
    tbl.push_back(mk("ab_drdy",    1, 0, 0, 0, 0, 1, G_D, 0, 1));
    tbl.push_back(mk("ab_end",     1, 0, 0, 0, 0, 0, G_N, 0, 0));
    tbl.push_back(mk("mr_arb",     1, 0, 0, 1, 0, 0, G_N, 0, 0));
    tbl.push_back(mk("mr_gd",      1, 0, 0, 1, 0, 0, G_D, 0, 0));
    tbl.push_back(mk("mr_rst",     0, 0, 0, 1, 0, 0, G_D, 0, 0));
    tbl.push_back(mk("mr_after",   1, 0, 0, 0, 0, 1, G_N, 0, 0));
    tbl.push_back(mk("mr_after2",  1, 0, 0, 0, 0, 1, G_N, 0, 0));
    tbl.push_back(mk("hi_arb",     1, 1, 0, 0, 0, 0, G_N, 0, 0));
    tbl.push_back(mk("hi_gi",      1, 1, 0, 1, 0, 0, G_I, 0, 0));
    tbl.push_back(mk("hi_irdy",    1, 0, 0, 1, 0, 1, G_I, 1, 0));
    tbl.push_back(mk("hi_drdy",    1, 0, 0, 0, 0, 1, G_D, 0, 1));
    tbl.push_back(mk("hi_idle",    1, 0, 0, 0, 0, 0, G_N, 0, 0));
    tbl.push_back(mk("rw_arb",     1, 0, 0, 1, 1, 0, G_N, 0, 0));
    tbl.push_back(mk("rw_gd",      1, 0, 0, 1, 1, 0, G_D, 0, 0));
    tbl.push_back(mk("rw_drdy",    1, 0, 0, 0, 0, 1, G_D, 0, 1));
    tbl.push_back(mk("rw_idle",    1, 0, 0, 0, 0, 0, G_N, 0, 0));

`ifndef MEM_ARB_ROUND_ROBIN_EN
    foreach (tbl[k]) apply(tbl[k]);
`endif

    // Fresh reset so last_grant starts at I, then four identical ties.
    apply(mk("seq_rst0", 0, 0, 0, 0, 0, 0, G_N, 0, 0));
    apply(mk("seq_rst1", 0, 0, 0, 0, 0, 0, G_N, 0, 0));
    for (int r = 0; r < 4; r++) tie_round($sformatf("rep%0d", r), 1'b1);

    // A lone D transfer completes last; the next tie exposes the arbitration policy.
    apply(mk("pol_arb",  1, 0, 0, 1, 0, 0, G_N, 0, 0));
    apply(mk("pol_gd",   1, 0, 0, 1, 0, 0, G_D, 0, 0));
    apply(mk("pol_drdy", 1, 0, 0, 0, 0, 1, G_D, 0, 1));
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tie_round("pol_tie", 1'b0);
`else
    tie_round("pol_tie", 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, line address width shared with the cache memory port.
REQ-002 Parameter LINE_W, default 128, cache line data width.
REQ-003 Ports: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Ports: proc_reset_n  input  1  reset, synchronous, active-low.
REQ-005 Ports: i_read / i_write  input  1 each  I-cache request lines, held until i_ready.
REQ-006 Ports: i_addr  input  ADDR_W  I-cache line address; i_wdata  input  LINE_W  I-cache write line.
REQ-007 Ports: i_rdata  output  LINE_W  read line to I-cache; i_ready  output  1  I-cache completion strobe.
REQ-008 Ports: d_read, d_write, d_addr, d_wdata, d_rdata, d_ready: D-cache port, identical widths and semantics to the I-cache port.
REQ-009 Ports: mem_read / mem_write  output  1 each  request to the shared memory.
REQ-010 Ports: mem_addr  output  ADDR_W; mem_wdata  output  LINE_W  forwarded request from the granted port.
REQ-011 Ports: mem_rdata  input  LINE_W; mem_ready  input  1  memory completion strobe.

Function
REQ-012 The state machine SHALL have exactly three states: IDLE, GNT_I, GNT_D.
REQ-013 A port requests when read|write is high.
- In IDLE, a requesting port SHALL be selected per REQ-015/REQ-016.
- The state SHALL move to GNT_x on the next edge.
- Arbitration latency SHALL be one cycle.
REQ-014 In IDLE:
- mem_read, mem_write, mem_addr and mem_wdata SHALL be 0.
- i_ready and d_ready SHALL be 0.
- No request SHALL keep the state in IDLE.
REQ-015 In GNT_x:
- mem_read, mem_write, mem_addr and mem_wdata SHALL combinationally equal the granted port's inputs.
- x_ready SHALL equal mem_ready.
- x_rdata SHALL equal mem_rdata.
- The non-granted port's ready and rdata SHALL be 0.
REQ-016 On mem_ready in GNT_x, the state SHALL go to the other GNT state if the other port requests that cycle, else to IDLE.
- Exception: with fixed priority (REQ-022 absent), a GNT_I completion while d requests SHALL go to GNT_D.
- Exception: with fixed priority, a GNT_D completion SHALL go to GNT_D if d still requests, else to GNT_I if i requests, else to IDLE.
REQ-017 If the granted port drops both read and write before mem_ready, the state SHALL return to IDLE on the next edge.
- The abandoned transfer SHALL NOT be completed.
- mem outputs SHALL already be 0 in that cycle, since they follow the port.
REQ-018 A grant SHALL never change while mem_ready is low and the granted port still requests (no preemption).
REQ-019 Simultaneous read and write on one port SHALL be forwarded unchanged; the arbiter does not resolve it.
REQ-020 A mem_ready arriving in IDLE SHALL be ignored and produce no ready on either port.

Reset
REQ-021 While proc_reset_n is low at a clock edge:
- The state SHALL become IDLE.
- last_grant SHALL become I.
- All outputs SHALL be 0 from the following cycle.
- A grant in progress SHALL be dropped without completion.

Configuration
REQ-022 Macro MEM_ARB_ROUND_ROBIN_EN:
- Defined: IDLE ties SHALL go to the port not in last_grant, a register updated on each mem_ready completion; REQ-016 alternation applies.
- Undefined: D-cache SHALL have fixed priority in IDLE ties and in REQ-016 handoffs, and last_grant SHALL not be synthesized.

Structure
REQ-023 The state encoding (IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2) and the ADDR_W/LINE_W defaults SHALL reside in shared package mem_arb_pkg.
REQ-024 Next-grant selection SHALL be a sub-module mem_arb_sel, with inputs i_req, d_req and last_grant and output grant_d.
- Datapath muxing and the FSM SHALL stay in mem_arbiter.

Verification
REQ-025 Reset then only d_read=1 with d_addr=28'h0000010: GNT_D one cycle later, mem_addr=28'h0000010, mem_read=1; mem_ready after 4 cycles -> d_ready=1 with d_rdata=mem_rdata in that same cycle, then IDLE.
REQ-026 i_read and d_write high together in IDLE, fixed priority: D is served first with mem_write=1 and mem_wdata=d_wdata; on its mem_ready the state moves directly to GNT_I with no IDLE cycle.
REQ-027 Same stimulus as REQ-026 repeated 4 times with MEM_ARB_ROUND_ROBIN_EN defined: grants alternate D,I,D,I,... after the first tie.
REQ-028 D write-back followed by D refill while i_read is pending, fixed priority: both D transfers complete before I is granted.
REQ-029 In GNT_I, i_read drops before mem_ready -> IDLE next cycle, no i_ready pulse; a pending d_read is granted one cycle later.
REQ-030 proc_reset_n=0 for one cycle mid-GNT_D -> IDLE and all outputs 0; a later mem_ready does not raise d_ready.
